// File: rtl/fan_ctrl.sv
// fan_ctrl: closed-loop fan PWM duty sequencer.
//   Runs a full-duty spin-up kick, then regulates the duty command toward a
//   target tach period once per update interval. Detects stalls, retries
//   spin-up, and latches a fail-safe FAULT state.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   tsc_1ppms           - one-cycle pulse every 1 ms
//   enable              - level, 0 forces OFF
//   auto_en             - 1 closed loop, 0 manual duty
//   manual_pct[7:0]     - manual duty command
//   target_uspr[19:0]   - target tach period (us)
//   hyst_us[15:0]       - regulation dead band (us)
//   fan_uspr[19:0]      - measured tach period (us), saturating
//   fan_pct[7:0]        - registered duty command
//   fan_state[1:0]      - 0 OFF, 1 SPINUP, 2 RUN, 3 FAULT
//   fan_fault           - high while in FAULT
module fan_ctrl #(
  parameter int unsigned SPINUP_MS = 2000,
  parameter int unsigned UPDATE_MS = 100,
  parameter int unsigned STEP      = 4,
  parameter logic [7:0]  MIN_PCT   = 8'h30,
  parameter logic [19:0] STALL_US  = 20'd200000,
  parameter int unsigned STALL_CNT = 5,
  parameter int unsigned RETRIES   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tsc_1ppms,
  input  logic        enable,
  input  logic        auto_en,
  input  logic [7:0]  manual_pct,
  input  logic [19:0] target_uspr,
  input  logic [15:0] hyst_us,
  input  logic [19:0] fan_uspr,
  output logic [7:0]  fan_pct,
  output logic [1:0]  fan_state,
  output logic        fan_fault
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned STALL_W = 4;
  localparam int unsigned RETRY_W = 3;
  localparam int unsigned ARITH_W = 21;

  localparam logic [CNT_W-1:0]   SPIN_LOAD = CNT_W'(SPINUP_MS);
  localparam logic [CNT_W-1:0]   UPD_LAST  = CNT_W'(UPDATE_MS - 1);
  localparam logic [7:0]         STEP_V    = 8'(STEP);
  localparam logic [STALL_W-1:0] STALL_TGT = STALL_W'(STALL_CNT);
  localparam logic [RETRY_W-1:0] RETRY_TGT = RETRY_W'(RETRIES);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SPINUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t               r_state;
  logic [7:0]           r_pct;
  logic                 r_fault;
  logic [CNT_W-1:0]     r_spin_cnt;
  logic [CNT_W-1:0]     r_upd_cnt;
  logic [STALL_W-1:0]   r_stall_cnt;
  logic [RETRY_W-1:0]   r_retry_cnt;

  // Regulation window, 21-bit so target + hyst cannot wrap
  logic [ARITH_W-1:0]   w_hi_bound;
  logic [ARITH_W-1:0]   w_lo_bound;
  logic                 w_lo_valid;
  logic                 w_too_slow;
  logic                 w_too_fast;
  logic [8:0]           w_sum;
  logic [8:0]           w_dn_floor;
  logic [7:0]           w_pct_up;
  logic [7:0]           w_pct_dn;
  logic [7:0]           w_manual;
  logic                 w_upd_evt;
  logic                 w_stalled;
  logic [STALL_W-1:0]   w_stall_next;
  logic [RETRY_W-1:0]   w_retry_next;

  assign w_hi_bound   = ARITH_W'(target_uspr) + ARITH_W'(hyst_us);
  assign w_lo_valid   = (target_uspr >= 20'(hyst_us));
  assign w_lo_bound   = ARITH_W'(target_uspr) - ARITH_W'(hyst_us);
  assign w_too_slow   = (ARITH_W'(fan_uspr) > w_hi_bound);
  // Lower bound only meaningful when hyst does not exceed target
  assign w_too_fast   = w_lo_valid && (ARITH_W'(fan_uspr) < w_lo_bound);

  // Duty step up saturates at 255; step down compares before subtracting
  assign w_sum        = 9'(r_pct) + 9'(STEP_V);
  assign w_pct_up     = w_sum[8] ? 8'hFF : w_sum[7:0];
  assign w_dn_floor   = 9'(MIN_PCT) + 9'(STEP_V);
  assign w_pct_dn     = (9'(r_pct) >= w_dn_floor) ? (r_pct - STEP_V) : MIN_PCT;

  assign w_manual     = (manual_pct < MIN_PCT) ? MIN_PCT : manual_pct;
  assign w_upd_evt    = tsc_1ppms && (r_upd_cnt == UPD_LAST);
  assign w_stalled    = (fan_uspr >= STALL_US);
  assign w_stall_next = r_stall_cnt + STALL_W'(1);
  assign w_retry_next = r_retry_cnt + RETRY_W'(1);

  // Sequencer: state, duty, fault flag and all interval counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_OFF;
      r_pct       <= 8'h00;
      r_fault     <= 1'b0;
      r_spin_cnt  <= '0;
      r_upd_cnt   <= '0;
      r_stall_cnt <= '0;
      r_retry_cnt <= '0;
    end else if (!enable) begin
      // Disable wins over any tick in the same cycle
      r_state     <= ST_OFF;
      r_pct       <= 8'h00;
      r_fault     <= 1'b0;
      r_spin_cnt  <= '0;
      r_upd_cnt   <= '0;
      r_stall_cnt <= '0;
      r_retry_cnt <= '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_state     <= ST_SPINUP;
          r_pct       <= 8'hFF;
          r_fault     <= 1'b0;
          r_spin_cnt  <= SPIN_LOAD;
          r_upd_cnt   <= '0;
          r_stall_cnt <= '0;
          r_retry_cnt <= '0;
        end

        ST_SPINUP: begin
          r_pct <= 8'hFF;
          if (tsc_1ppms) begin
            if (r_spin_cnt <= CNT_W'(1)) begin
              r_state     <= ST_RUN;
              r_spin_cnt  <= '0;
              r_upd_cnt   <= '0;
              r_stall_cnt <= '0;
              r_pct       <= auto_en ? 8'hFF : w_manual;
            end else begin
              r_spin_cnt <= r_spin_cnt - CNT_W'(1);
            end
          end
        end

        ST_RUN: begin
          // Manual duty tracks the input every cycle; auto holds between updates
          if (!auto_en) begin
            r_pct <= w_manual;
          end
          if (tsc_1ppms) begin
            if (w_upd_evt) begin
              r_upd_cnt <= '0;
              if (auto_en) begin
                if (w_too_slow) begin
                  r_pct <= w_pct_up;
                end else if (w_too_fast) begin
                  r_pct <= w_pct_dn;
                end
              end
              if (w_stalled) begin
                if (w_stall_next == STALL_TGT) begin
                  r_stall_cnt <= '0;
                  r_retry_cnt <= w_retry_next;
                  r_pct       <= 8'hFF;
                  if (w_retry_next == RETRY_TGT) begin
                    r_state <= ST_FAULT;
                    r_fault <= 1'b1;
                  end else begin
                    r_state    <= ST_SPINUP;
                    r_spin_cnt <= SPIN_LOAD;
                  end
                end else begin
                  r_stall_cnt <= w_stall_next;
                end
              end else begin
                // A healthy sample forgives earlier retries
                r_stall_cnt <= '0;
                r_retry_cnt <= '0;
              end
            end else begin
              r_upd_cnt <= r_upd_cnt + CNT_W'(1);
            end
          end
        end

        ST_FAULT: begin
          // Fail-safe full cooling until disabled or reset
          r_pct   <= 8'hFF;
          r_fault <= 1'b1;
        end

        default: begin
          r_state <= ST_OFF;
          r_pct   <= 8'h00;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

  assign fan_pct   = r_pct;
  assign fan_state = r_state;
  assign fan_fault = r_fault;

endmodule

// File: tb/tb_fan_ctrl.sv
// Directed self-checking bench for fan_ctrl.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge that follows the rising edge under test.
module tb_fan_ctrl;

  logic        clk;
  logic        rst;
  logic        tsc_1ppms;
  logic        enable;
  logic        auto_en;
  logic [7:0]  manual_pct;
  logic [19:0] target_uspr;
  logic [15:0] hyst_us;
  logic [19:0] fan_uspr;
  logic [7:0]  fan_pct;
  logic [1:0]  fan_state;
  logic        fan_fault;

  int n_cmp;
  int n_err;

  fan_ctrl #(
    .SPINUP_MS(4),
    .UPDATE_MS(2),
    .STEP(4),
    .MIN_PCT(8'h30),
    .STALL_US(20'd200000),
    .STALL_CNT(2),
    .RETRIES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tsc_1ppms(tsc_1ppms),
    .enable(enable),
    .auto_en(auto_en),
    .manual_pct(manual_pct),
    .target_uspr(target_uspr),
    .hyst_us(hyst_us),
    .fan_uspr(fan_uspr),
    .fan_pct(fan_pct),
    .fan_state(fan_state),
    .fan_fault(fan_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One idle clock
  task automatic cyc();
    @(negedge clk);
  endtask

  // One 1 ms tick, with an idle cycle after it
  task automatic tick();
    tsc_1ppms = 1'b1;
    @(negedge clk);
    tsc_1ppms = 1'b0;
    @(negedge clk);
  endtask

  // One update interval (UPDATE_MS = 2 ticks)
  task automatic upd();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    auto_en = 1'b1;
    tsc_1ppms = 1'b0;
    manual_pct = 8'h00;
    target_uspr = 20'd10000;
    hyst_us = 16'd500;
    fan_uspr = 20'd10000;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    n_cmp++; if (fan_state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", fan_state); end
    n_cmp++; if (fan_pct !== 8'h00) begin n_err++; $display("FAIL rst_pct got %h want 00", fan_pct); end
    n_cmp++; if (fan_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault got %b want 0", fan_fault); end
  endtask

  task automatic test_enable_spinup();
    enable = 1'b1;
    cyc();
    n_cmp++; if (fan_state !== 2'd1) begin n_err++; $display("FAIL en_state got %0d want 1", fan_state); end
    n_cmp++; if (fan_pct !== 8'hFF) begin n_err++; $display("FAIL en_pct got %h want ff", fan_pct); end
    repeat (3) tick();
    n_cmp++; if (fan_state !== 2'd1) begin n_err++; $display("FAIL spin3_state got %0d want 1", fan_state); end
    tick();
    n_cmp++; if (fan_state !== 2'd2) begin n_err++; $display("FAIL spin4_state got %0d want 2", fan_state); end
    n_cmp++; if (fan_pct !== 8'hFF) begin n_err++; $display("FAIL run_entry_pct got %h want ff", fan_pct); end
  endtask

  task automatic test_auto_regulation();
    fan_uspr = 20'd8000;
    tick();
    n_cmp++; if (fan_pct !== 8'hFF) begin n_err++; $display("FAIL no_evt_pct got %h want ff", fan_pct); end
    tick();
    n_cmp++; if (fan_pct !== 8'hFB) begin n_err++; $display("FAIL dn1_pct got %h want fb", fan_pct); end
    for (int i = 0; i < 60; i++) upd();
    n_cmp++; if (fan_pct !== 8'h30) begin n_err++; $display("FAIL dn_floor_pct got %h want 30", fan_pct); end
    fan_uspr = 20'd12000;
    upd();
    n_cmp++; if (fan_pct !== 8'h34) begin n_err++; $display("FAIL up1_pct got %h want 34", fan_pct); end
    for (int i = 0; i < 60; i++) upd();
    n_cmp++; if (fan_pct !== 8'hFF) begin n_err++; $display("FAIL up_sat_pct got %h want ff", fan_pct); end
    fan_uspr = 20'd8000;
    repeat (3) upd();
    n_cmp++; if (fan_pct !== 8'hF3) begin n_err++; $display("FAIL dn3_pct got %h want f3", fan_pct); end
    fan_uspr = 20'd10400;
    repeat (3) upd();
    n_cmp++; if (fan_pct !== 8'hF3) begin n_err++; $display("FAIL hold_pct got %h want f3", fan_pct); end
    fan_uspr = 20'd10500;
    upd();
    n_cmp++; if (fan_pct !== 8'hF3) begin n_err++; $display("FAIL hi_edge_pct got %h want f3", fan_pct); end
    fan_uspr = 20'd9500;
    upd();
    n_cmp++; if (fan_pct !== 8'hF3) begin n_err++; $display("FAIL lo_edge_pct got %h want f3", fan_pct); end
    fan_uspr = 20'd10501;
    upd();
    n_cmp++; if (fan_pct !== 8'hF7) begin n_err++; $display("FAIL hi_over_pct got %h want f7", fan_pct); end
    n_cmp++; if (fan_state !== 2'd2) begin n_err++; $display("FAIL reg_state got %0d want 2", fan_state); end
  endtask

  task automatic test_stall_fault();
    fan_uspr = 20'hFFFFF;
    upd();
    n_cmp++; if (fan_state !== 2'd2) begin n_err++; $display("FAIL stall1_state got %0d want 2", fan_state); end
    n_cmp++; if (fan_pct !== 8'hFB) begin n_err++; $display("FAIL stall1_pct got %h want fb", fan_pct); end
    upd();
    n_cmp++; if (fan_state !== 2'd1) begin n_err++; $display("FAIL retry1_state got %0d want 1", fan_state); end
    n_cmp++; if (fan_pct !== 8'hFF) begin n_err++; $display("FAIL retry1_pct got %h want ff", fan_pct); end
    repeat (4) tick();
    n_cmp++; if (fan_state !== 2'd2) begin n_err++; $display("FAIL respin1_state got %0d want 2", fan_state); end
    repeat (2) upd();
    n_cmp++; if (fan_state !== 2'd1) begin n_err++; $display("FAIL retry2_state got %0d want 1", fan_state); end
    repeat (4) tick();
    upd();
    n_cmp++; if (fan_state !== 2'd2) begin n_err++; $display("FAIL stall3a_state got %0d want 2", fan_state); end
    upd();
    n_cmp++; if (fan_state !== 2'd3) begin n_err++; $display("FAIL fault_state got %0d want 3", fan_state); end
    n_cmp++; if (fan_pct !== 8'hFF) begin n_err++; $display("FAIL fault_pct got %h want ff", fan_pct); end
    n_cmp++; if (fan_fault !== 1'b1) begin n_err++; $display("FAIL fault_flag got %b want 1", fan_fault); end
    repeat (4) tick();
    n_cmp++; if (fan_state !== 2'd3) begin n_err++; $display("FAIL fault_hold got %0d want 3", fan_state); end
    enable = 1'b0;
    cyc();
    n_cmp++; if (fan_state !== 2'd0) begin n_err++; $display("FAIL off_state got %0d want 0", fan_state); end
    n_cmp++; if (fan_pct !== 8'h00) begin n_err++; $display("FAIL off_pct got %h want 00", fan_pct); end
    n_cmp++; if (fan_fault !== 1'b0) begin n_err++; $display("FAIL off_fault got %b want 0", fan_fault); end
  endtask

  task automatic test_retry_clear();
    enable = 1'b1;
    cyc();
    repeat (4) tick();
    repeat (2) upd();
    n_cmp++; if (fan_state !== 2'd1) begin n_err++; $display("FAIL rc_retry1 got %0d want 1", fan_state); end
    repeat (4) tick();
    fan_uspr = 20'd9000;
    upd();
    n_cmp++; if (fan_state !== 2'd2) begin n_err++; $display("FAIL rc_healthy_state got %0d want 2", fan_state); end
    n_cmp++; if (fan_pct !== 8'hFB) begin n_err++; $display("FAIL rc_healthy_pct got %h want fb", fan_pct); end
    fan_uspr = 20'hFFFFF;
    repeat (2) upd();
    n_cmp++; if (fan_state !== 2'd1) begin n_err++; $display("FAIL rc_seq1 got %0d want 1", fan_state); end
    repeat (4) tick();
    repeat (2) upd();
    n_cmp++; if (fan_state !== 2'd1) begin n_err++; $display("FAIL rc_seq2 got %0d want 1", fan_state); end
    repeat (4) tick();
    repeat (2) upd();
    n_cmp++; if (fan_state !== 2'd3) begin n_err++; $display("FAIL rc_seq3 got %0d want 3", fan_state); end
    enable = 1'b0;
    cyc();
  endtask

  task automatic test_manual();
    fan_uspr = 20'd10000;
    auto_en = 1'b0;
    manual_pct = 8'h10;
    enable = 1'b1;
    cyc();
    repeat (4) tick();
    n_cmp++; if (fan_state !== 2'd2) begin n_err++; $display("FAIL man_state got %0d want 2", fan_state); end
    n_cmp++; if (fan_pct !== 8'h30) begin n_err++; $display("FAIL man_clamp got %h want 30", fan_pct); end
    manual_pct = 8'hA0;
    cyc();
    n_cmp++; if (fan_pct !== 8'hA0) begin n_err++; $display("FAIL man_a0 got %h want a0", fan_pct); end
    auto_en = 1'b1;
    fan_uspr = 20'd12000;
    cyc();
    n_cmp++; if (fan_pct !== 8'hA0) begin n_err++; $display("FAIL m2a_hold got %h want a0", fan_pct); end
    upd();
    n_cmp++; if (fan_pct !== 8'hA4) begin n_err++; $display("FAIL m2a_up got %h want a4", fan_pct); end
    auto_en = 1'b0;
    manual_pct = 8'h50;
    cyc();
    n_cmp++; if (fan_pct !== 8'h50) begin n_err++; $display("FAIL a2m got %h want 50", fan_pct); end
  endtask

  task automatic test_abort();
    enable = 1'b0;
    cyc();
    auto_en = 1'b1;
    fan_uspr = 20'd10000;
    enable = 1'b1;
    cyc();
    repeat (2) tick();
    enable = 1'b0;
    tsc_1ppms = 1'b1;
    cyc();
    tsc_1ppms = 1'b0;
    n_cmp++; if (fan_state !== 2'd0) begin n_err++; $display("FAIL abort_state got %0d want 0", fan_state); end
    n_cmp++; if (fan_pct !== 8'h00) begin n_err++; $display("FAIL abort_pct got %h want 00", fan_pct); end
    enable = 1'b1;
    cyc();
    repeat (3) tick();
    n_cmp++; if (fan_state !== 2'd1) begin n_err++; $display("FAIL abort_reload got %0d want 1", fan_state); end
    tick();
    n_cmp++; if (fan_state !== 2'd2) begin n_err++; $display("FAIL abort_run got %0d want 2", fan_state); end
  endtask

  task automatic test_hyst_guard();
    target_uspr = 20'd100;
    hyst_us = 16'd500;
    fan_uspr = 20'd0;
    repeat (3) upd();
    n_cmp++; if (fan_pct !== 8'hFF) begin n_err++; $display("FAIL hyst_guard got %h want ff", fan_pct); end
    n_cmp++; if (fan_state !== 2'd2) begin n_err++; $display("FAIL hyst_state got %0d want 2", fan_state); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_enable_spinup();
    test_auto_regulation();
    test_stall_fault();
    test_retry_clear();
    test_manual();
    test_abort();
    test_hyst_guard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
